// File: rtl/mag_comp_debounce_mon.sv
// Magnitude comparator consumer: debounces the L/G/E result of a valid/ready sample stream
// and keeps saturating event counters. Define CMP_SIGNED_EN for two's-complement compare.
module mag_comp_debounce_mon #(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             L,
  output logic             G,
  output logic             E,
  output logic             chg,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt
);

  typedef enum logic [1:0] {IDLE, ST_LT, ST_GT, ST_EQ} state_t;
  typedef enum logic [1:0] {RES_LT, RES_GT, RES_EQ} res_t;

  localparam int RUN_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [RUN_W-1:0] DEB_MAX = RUN_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  res_t             cand_q, cand_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;

  logic accept;
  logic a_lt_b;
  res_t raw;

  function automatic state_t to_state(input res_t r);
    case (r)
      RES_LT:  return ST_LT;
      RES_GT:  return ST_GT;
      default: return ST_EQ;
    endcase
  endfunction

  assign in_ready = ~clr;
  assign accept   = in_valid & ~clr;

`ifdef CMP_SIGNED_EN
  assign a_lt_b = $signed(A) < $signed(B);
`else
  assign a_lt_b = A < B;
`endif

  assign raw = (A == B) ? RES_EQ : (a_lt_b ? RES_LT : RES_GT);

  // NOTE: every variable gets its default first so no path through the block infers a latch.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    run_d    = run_q;
    run_inc  = '0;
    chg_d    = 1'b0;
    lt_cnt_d = lt_cnt_q;
    gt_cnt_d = gt_cnt_q;
    eq_cnt_d = eq_cnt_q;

    if (clr) begin
      state_d  = IDLE;
      cand_d   = RES_EQ;
      run_d    = '0;
      lt_cnt_d = '0;
      gt_cnt_d = '0;
      eq_cnt_d = '0;
    end else if (accept) begin
      if (to_state(raw) == state_q) begin
        run_d = '0;
      end else begin
        // IDLE never matches a raw result, so the first pair always starts or extends a run.
        if (raw == cand_q) begin
          run_inc = run_q + 1'b1;
        end else begin
          cand_d  = raw;
          run_inc = RUN_W'(1);
        end
        if (run_inc == DEB_MAX) begin
          state_d = to_state(raw);
          chg_d   = 1'b1;
          run_d   = '0;
        end else begin
          run_d = run_inc;
        end
      end

      unique case (raw)
        RES_LT:  if (lt_cnt_q != '1) lt_cnt_d = lt_cnt_q + CNT_ONE;
        RES_GT:  if (gt_cnt_q != '1) gt_cnt_d = gt_cnt_q + CNT_ONE;
        default: if (eq_cnt_q != '1) eq_cnt_d = eq_cnt_q + CNT_ONE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cand_q   <= RES_EQ;
      run_q    <= '0;
      chg_q    <= 1'b0;
      lt_cnt_q <= '0;
      gt_cnt_q <= '0;
      eq_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      run_q    <= run_d;
      chg_q    <= chg_d;
      lt_cnt_q <= lt_cnt_d;
      gt_cnt_q <= gt_cnt_d;
      eq_cnt_q <= eq_cnt_d;
    end
  end

  assign L      = (state_q == ST_LT);
  assign G      = (state_q == ST_GT);
  assign E      = (state_q == ST_EQ);
  assign chg    = chg_q;
  assign lt_cnt = lt_cnt_q;
  assign gt_cnt = gt_cnt_q;
  assign eq_cnt = eq_cnt_q;

endmodule

// File: tb/tb_mag_comp_debounce_mon.sv
// Directed bench for mag_comp_debounce_mon: default build, plus a CNT_W=2 and a
// DEBOUNCE=1 instance sharing the same stimulus.
module tb_mag_comp_debounce_mon;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid;
  logic [3:0] A, B;

  logic       in_ready, L, G, E, chg;
  logic [7:0] lt_cnt, gt_cnt, eq_cnt;

  logic       r2_ready, L2, G2, E2, chg2;
  logic [1:0] lt2, gt2, eq2;

  logic       r3_ready, L3, G3, E3, chg3;
  logic [7:0] lt3, gt3, eq3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mag_comp_debounce_mon #(.WIDTH(4), .DEBOUNCE(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .L(L), .G(G), .E(E), .chg(chg),
    .lt_cnt(lt_cnt), .gt_cnt(gt_cnt), .eq_cnt(eq_cnt)
  );

  mag_comp_debounce_mon #(.WIDTH(4), .DEBOUNCE(3), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(r2_ready),
    .A(A), .B(B), .L(L2), .G(G2), .E(E2), .chg(chg2),
    .lt_cnt(lt2), .gt_cnt(gt2), .eq_cnt(eq2)
  );

  mag_comp_debounce_mon #(.WIDTH(4), .DEBOUNCE(1), .CNT_W(8)) dut_d1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(r3_ready),
    .A(A), .B(B), .L(L3), .G(G3), .E(E3), .chg(chg3),
    .lt_cnt(lt3), .gt_cnt(gt3), .eq_cnt(eq3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {L,G,E,chg} packed for compact checks
  task automatic check_lgec(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, L, G, E, chg}, {28'd0, exp});
  endtask

  // One accepted pair: driven at the falling edge, outputs settle 1 time unit after the rising edge.
  task automatic pair(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b1; in_valid = 1'b0; A = '0; B = '0;
    #2;
    check("ready_clr_in_rst", {31'd0, in_ready}, 32'd0);
    clr = 1'b0;
    #1;
    check("ready_in_rst", {31'd0, in_ready}, 32'd1);
    check_lgec("reset_lgec", 4'b0000);
    check("reset_cnts", {8'd0, lt_cnt, gt_cnt, eq_cnt}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Three GT pairs switch IDLE -> GT on the third
    pair(4'd10, 4'd5);
    check_lgec("gt1_lgec", 4'b0000);
    check("d1_gt1_lgec", {28'd0, L3, G3, E3, chg3}, 32'b0101);
    pair(4'd10, 4'd5);
    check_lgec("gt2_lgec", 4'b0000);
    check("d1_gt2_chg", {31'd0, chg3}, 32'd0);
    pair(4'd10, 4'd5);
    check_lgec("gt3_lgec", 4'b0101);
    check("gt3_gtcnt", {24'd0, gt_cnt}, 32'd3);
    idle(1);
    check_lgec("gt_hold_lgec", 4'b0100);

    // LT run interrupted by a GT pair restarts; three consecutive LTs switch
    pair(4'd5, 4'd6);
    pair(4'd5, 4'd6);
    check_lgec("lt2_lgec", 4'b0100);
    pair(4'd10, 4'd5);
    check_lgec("gt_intr_lgec", 4'b0100);
    pair(4'd5, 4'd6);
    pair(4'd5, 4'd6);
    check_lgec("lt_r2_lgec", 4'b0100);
    pair(4'd5, 4'd6);
    check_lgec("lt_r3_lgec", 4'b1001);
    check("lt_cnts", {8'd0, lt_cnt, gt_cnt, eq_cnt}, {8'd0, 8'd5, 8'd4, 8'd0});

    // Idle gaps between EQ pairs do not break the run
    pair(4'd10, 4'd10);
    idle(4);
    pair(4'd10, 4'd10);
    idle(4);
    check_lgec("eq_gap2_lgec", 4'b1000);
    pair(4'd10, 4'd10);
    check_lgec("eq_gap3_lgec", 4'b0011);
    check("eq_gap_cnt", {24'd0, eq_cnt}, 32'd3);

    // Async reset mid-run discards progress
    pair(4'd10, 4'd5);
    pair(4'd10, 4'd5);
    @(negedge clk) rst = 1'b1;
    #1;
    check_lgec("rst_mid_lgec", 4'b0000);
    check("rst_mid_cnts", {8'd0, lt_cnt, gt_cnt, eq_cnt}, 32'd0);
    @(negedge clk) rst = 1'b0;
    pair(4'd10, 4'd5);
    pair(4'd10, 4'd5);
    check_lgec("rst_gt2_lgec", 4'b0000);
    pair(4'd10, 4'd5);
    check_lgec("rst_gt3_lgec", 4'b0101);
    check("rst_gt_cnt", {24'd0, gt_cnt}, 32'd3);

    // Clear, then saturation on the narrow-counter instance
    @(negedge clk) clr = 1'b1;
    @(posedge clk) #1;
    clr = 1'b0;
    check_lgec("clr1_lgec", 4'b0000);
    check("clr1_c2_cnts", {26'd0, lt2, gt2, eq2}, 32'd0);
    repeat (6) pair(4'd7, 4'd7);
    check("sat_eq_c2", {30'd0, eq2}, 32'd3);
    check("sat_eq_main", {24'd0, eq_cnt}, 32'd6);
    check("sat_E", {31'd0, E}, 32'd1);

    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; A = 4'd7; B = 4'd7;
    #1;
    check("clr_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk) #1;
    check_lgec("clr2_lgec", 4'b0000);
    check("clr2_cnts", {8'd0, lt_cnt, gt_cnt, eq_cnt}, 32'd0);
    check("clr2_c2_eq", {30'd0, eq2}, 32'd0);
    @(negedge clk) begin clr = 1'b0; in_valid = 1'b0; end
    idle(1);
    check("clr2_hold_eq", {24'd0, eq_cnt}, 32'd0);

    // Signedness: -8 vs 1 under the signed build, 8 vs 1 otherwise
    repeat (3) pair(4'b1000, 4'b0001);
`ifdef CMP_SIGNED_EN
    check_lgec("sign_lgec", 4'b1001);
`else
    check_lgec("sign_lgec", 4'b0101);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
